// File: rtl/addsub_arbiter_if.sv
// Requester/consumer bus for the shared adder-subtractor arbiter.
// Optional feature macro: ADDSUB_ARB_OVF_EN adds the res_ovf signal.
interface addsub_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*N-1:0] a;
  logic [NREQ*N-1:0] b;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [N-1:0]      res_s;
  logic              res_cout;
`ifdef ADDSUB_ARB_OVF_EN
  logic              res_ovf;
`endif

`ifdef ADDSUB_ARB_OVF_EN
  modport master (
    output req, op, a, b, res_ready,
    input  gnt, res_valid, res_id, res_s, res_cout, res_ovf
  );
  modport slave (
    input  req, op, a, b, res_ready,
    output gnt, res_valid, res_id, res_s, res_cout, res_ovf
  );
`else
  modport master (
    output req, op, a, b, res_ready,
    input  gnt, res_valid, res_id, res_s, res_cout
  );
  modport slave (
    input  req, op, a, b, res_ready,
    output gnt, res_valid, res_id, res_s, res_cout
  );
`endif
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder-subtractor among NREQ
// requesters, returning a registered result tagged with the requester id.
// Optional feature macro: ADDSUB_ARB_OVF_EN enables the signed overflow flag.
module addsub_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_arbiter_if.slave   bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] res_id_q;
  logic [N-1:0]   res_s_q;
  logic           res_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
  logic           res_ovf_q;
`endif

  logic            can_accept;
  logic            grant_any;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  idx_c;
  logic [NREQ-1:0] gnt_c;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic            op_sub;
  logic [N-1:0]    sum_c;
  logic            carry;
  logic            cout_c;
  logic            ovf_c;

  // Grants are blocked while in reset so nothing is accepted that would be discarded.
  assign can_accept = rst_n & ((state == IDLE) | bus.res_ready);

  // Round-robin search starting just after the last granted index.
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = ptr;
    idx_c     = ptr;
    gnt_c     = '0;
    if (can_accept) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx_c = IDW'((int'(ptr) + k) % NREQ);
        if (!grant_any && bus.req[idx_c]) begin
          grant_any = 1'b1;
          gnt_idx   = idx_c;
        end
      end
    end
    if (grant_any) gnt_c[gnt_idx] = 1'b1;
  end

  // Shared datapath: operand mux, B inversion and ripple-carry chain.
  always_comb begin
    op_a   = bus.a[int'(gnt_idx)*N +: N];
    op_sub = bus.op[gnt_idx];
    op_b   = bus.b[int'(gnt_idx)*N +: N] ^ {N{op_sub}};
    sum_c  = '0;
    carry  = op_sub;
    for (int i = 0; i < N; i++) begin
      sum_c[i] = op_a[i] ^ op_b[i] ^ carry;
      carry    = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
    end
    cout_c = carry;
    ovf_c  = (op_a[N-1] == op_b[N-1]) & (sum_c[N-1] != op_a[N-1]);
  end

  // Result register, round-robin pointer and the IDLE/RESP state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      res_id_q   <= '0;
      res_s_q    <= '0;
      res_cout_q <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      res_ovf_q  <= 1'b0;
`endif
    end else begin
      if (grant_any) begin
        ptr        <= gnt_idx;
        res_id_q   <= gnt_idx;
        res_s_q    <= sum_c;
        res_cout_q <= cout_c;
`ifdef ADDSUB_ARB_OVF_EN
        res_ovf_q  <= ovf_c;
`endif
      end
      case (state)
        IDLE: if (grant_any) state <= RESP;
        RESP: if (!grant_any && bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.res_valid = (state == RESP);
  assign bus.res_id    = res_id_q;
  assign bus.res_s     = res_s_q;
  assign bus.res_cout  = res_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign bus.res_ovf   = res_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_c;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter (N=4, NREQ=4).
// Optional feature macro: ADDSUB_ARB_OVF_EN adds overflow checks.
module tb_addsub_arbiter;
  localparam int N    = 4;
  localparam int NREQ = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  addsub_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  addsub_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive requests and consumer ready just after a falling edge.
  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] op, input logic ready);
    bus.req       = req;
    bus.op        = op;
    bus.res_ready = ready;
  endtask

  task automatic setOperands(input int idx, input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.a[idx*N +: N] = av;
    bus.b[idx*N +: N] = bv;
  endtask

  // Directed test sequence.
  initial begin
    checks = 0;
    fails  = 0;
    bus.a  = '0;
    bus.b  = '0;
    rst_n  = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);

    // Reset holds everything quiet even with all requests raised.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checkOutput("rst_gnt",   32'(bus.gnt), 32'h0);
      checkOutput("rst_valid", 32'(bus.res_valid), 32'h0);
      checkOutput("rst_s",     32'(bus.res_s), 32'h0);
      checkOutput("rst_id",    32'(bus.res_id), 32'h0);
      checkOutput("rst_cout",  32'(bus.res_cout), 32'h0);
    end

    // Round robin with all requesters active: a[i]=i, b[i]=1, so S=i+1.
    for (int i = 0; i < NREQ; i++) setOperands(i, 4'(i), 4'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      if (k > 0) begin
        checkOutput("rr_id",    32'(bus.res_id), 32'((k - 1) % 4));
        checkOutput("rr_s",     32'(bus.res_s), 32'(((k - 1) % 4) + 1));
        checkOutput("rr_valid", 32'(bus.res_valid), 32'h1);
      end
      @(negedge clk);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("rr_last_id", 32'(bus.res_id), 32'h0);
    checkOutput("rr_last_s",  32'(bus.res_s), 32'h1);
    @(negedge clk); #1;
    checkOutput("rr_drain_valid", 32'(bus.res_valid), 32'h0);

    // Single add on requester 1: 7+9 wraps to 0 with carry out.
    @(negedge clk);
    setOperands(1, 4'd7, 4'd9);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    #1;
    checkOutput("add_gnt", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("add_gnt_off", 32'(bus.gnt), 32'h0);
    checkOutput("add_valid",   32'(bus.res_valid), 32'h1);
    checkOutput("add_id",      32'(bus.res_id), 32'h1);
    checkOutput("add_s",       32'(bus.res_s), 32'h0);
    checkOutput("add_cout",    32'(bus.res_cout), 32'h1);
    @(negedge clk); #1;
    checkOutput("add_idle", 32'(bus.res_valid), 32'h0);

    // Subtract on requester 0: 3-5 = 14 with a borrow.
    @(negedge clk);
    setOperands(0, 4'd3, 4'd5);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    #1;
    checkOutput("sub_gnt", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("sub_s",    32'(bus.res_s), 32'hE);
    checkOutput("sub_cout", 32'(bus.res_cout), 32'h0);
    checkOutput("sub_id",   32'(bus.res_id), 32'h0);
`ifdef ADDSUB_ARB_OVF_EN
    checkOutput("sub_ovf",  32'(bus.res_ovf), 32'h0);
`endif

    // Signed overflow on requester 0: 7+1 = 8.
    @(negedge clk);
    setOperands(0, 4'd7, 4'd1);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    #1;
    checkOutput("ovf_gnt", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("ovf_s",    32'(bus.res_s), 32'h8);
    checkOutput("ovf_cout", 32'(bus.res_cout), 32'h0);
`ifdef ADDSUB_ARB_OVF_EN
    checkOutput("ovf_flag", 32'(bus.res_ovf), 32'h1);
`endif

    // Backpressure: result from requester 1 held while requester 2 waits.
    @(negedge clk);
    setOperands(1, 4'd7, 4'd9);
    setOperands(2, 4'd2, 4'd1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    #1;
    checkOutput("bp_first_gnt", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("bp_gnt",   32'(bus.gnt), 32'h0);
      checkOutput("bp_valid", 32'(bus.res_valid), 32'h1);
      checkOutput("bp_id",    32'(bus.res_id), 32'h1);
      checkOutput("bp_s",     32'(bus.res_s), 32'h0);
      checkOutput("bp_cout",  32'(bus.res_cout), 32'h1);
      @(negedge clk);
    end
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    #1;
    checkOutput("bp_release_gnt", 32'(bus.gnt), 32'h4);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("bp_next_valid", 32'(bus.res_valid), 32'h1);
    checkOutput("bp_next_id",    32'(bus.res_id), 32'h2);
    checkOutput("bp_next_s",     32'(bus.res_s), 32'h3);

    // Mid-operation asynchronous reset while a result is pending.
    @(negedge clk);
    setOperands(3, 4'd3, 4'd1);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #1;
    checkOutput("mr_valid_before", 32'(bus.res_valid), 32'h1);
    checkOutput("mr_s_before",     32'(bus.res_s), 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid_after", 32'(bus.res_valid), 32'h0);
    checkOutput("mr_s_after",     32'(bus.res_s), 32'h0);
    @(negedge clk);
    setOperands(1, 4'd5, 4'd2);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 4'b0000, 1'b1);
    #1;
    checkOutput("mr_first_gnt", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("mr_id", 32'(bus.res_id), 32'h1);
    checkOutput("mr_s",  32'(bus.res_s), 32'h7);

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
